// File: rtl/hit_serializer.sv
`default_nettype none
// =============================================================================
// hit_serializer : compacts valid R18 hit lanes into a FWFT FIFO, one hit out
//                  per cycle. Optional counters under HIT_SERIALIZER_STATS_EN.
// Revision       : 1.0
// =============================================================================

module hit_serializer #(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int AXIS       = 3,
  parameter int COLORS     = 3,
  parameter int MULTI_TEST = 4,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] hit_R18S [MULTI_TEST][AXIS],
  input  logic        [SIGFIG-1:0] color_R18U [COLORS],
  input  logic    [MULTI_TEST-1:0] hit_valid_R18H,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] hit_R19S [AXIS],
  output logic        [SIGFIG-1:0] color_R19U [COLORS],
  output logic                     hit_valid_R19H,
  input  logic                     halt_R19L,
  output logic  [$clog2(DEPTH):0]  occupancy
`ifdef HIT_SERIALIZER_STATS_EN
  ,
  output logic              [31:0] hits_in,
  output logic              [31:0] hits_out,
  output logic              [31:0] stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic signed [SIGFIG-1:0] pos_q [DEPTH][AXIS];
  logic        [SIGFIG-1:0] col_q [DEPTH][COLORS];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      npush;
  logic [PTR_W-1:0]      slot [MULTI_TEST];
  logic [MULTI_TEST-1:0] push_en;
  logic                  pop;

  assign halt_RnnnnL    = (count_q <= CNT_W'(DEPTH - MULTI_TEST));
  assign hit_valid_R19H = (count_q != '0);
  assign occupancy      = count_q;
  assign pop            = hit_valid_R19H & halt_R19L;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
  always_comb begin
    npush   = '0;
    push_en = '0;
    for (int i = 0; i < MULTI_TEST; i++) begin
      slot[i]    = wr_ptr_q + npush[PTR_W-1:0];
      push_en[i] = halt_RnnnnL & hit_valid_R18H[i];
      if (push_en[i]) begin
        npush = npush + CNT_W'(1);
      end
    end
  end

  always_comb begin
    count_d  = count_q + npush - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + npush[PTR_W-1:0];
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        for (int a = 0; a < AXIS; a++)   pos_q[s][a] <= '0;
        for (int c = 0; c < COLORS; c++) col_q[s][c] <= '0;
      end
    end else begin
      for (int i = 0; i < MULTI_TEST; i++) begin
        if (push_en[i]) begin
          for (int a = 0; a < AXIS; a++)   pos_q[slot[i]][a] <= hit_R18S[i][a];
          for (int c = 0; c < COLORS; c++) col_q[slot[i]][c] <= color_R18U[c];
        end
      end
    end
  end

  always_comb begin
    for (int a = 0; a < AXIS; a++)   hit_R19S[a]   = pos_q[rd_ptr_q][a];
    for (int c = 0; c < COLORS; c++) color_R19U[c] = col_q[rd_ptr_q][c];
  end

`ifdef HIT_SERIALIZER_STATS_EN
  logic [31:0] hits_in_q, hits_in_d;
  logic [31:0] hits_out_q, hits_out_d;
  logic [31:0] stall_q, stall_d;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CNT_W-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    hits_in_d  = sat_add(hits_in_q, npush);
    hits_out_d = sat_add(hits_out_q, CNT_W'(pop));
    stall_d    = sat_add(stall_q, CNT_W'(!halt_RnnnnL && (|hit_valid_R18H)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hits_in_q  <= '0;
      hits_out_q <= '0;
      stall_q    <= '0;
    end else begin
      hits_in_q  <= hits_in_d;
      hits_out_q <= hits_out_d;
      stall_q    <= stall_d;
    end
  end

  assign hits_in      = hits_in_q;
  assign hits_out     = hits_out_q;
  assign stall_cycles = stall_q;
`endif

`ifndef SYNTHESIS
  localparam bit CFG_OK = (DEPTH >= MULTI_TEST) && ((DEPTH & (DEPTH - 1)) == 0) &&
                          (RADIX < SIGFIG);

  logic [MULTI_TEST*AXIS*SIGFIG-1:0] hit_flat;

  always_comb begin
    hit_flat = '0;
    for (int i = 0; i < MULTI_TEST; i++) begin
      for (int a = 0; a < AXIS; a++) hit_flat[(i*AXIS+a)*SIGFIG +: SIGFIG] = hit_R18S[i][a];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (CFG_OK);
      assert (count_q <= CNT_W'(DEPTH));
    end
  end

  // Upstream must hold a refused group unchanged until it is taken.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (!halt_RnnnnL && (|hit_valid_R18H)) |=> $stable(hit_flat));
`endif

endmodule

`default_nettype wire

// File: tb/tb_hit_serializer.sv
`default_nettype none
// =============================================================================
// tb_hit_serializer : directed vector table plus queue-model sequences.
// Revision          : 1.0
// =============================================================================

module tb_hit_serializer;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [23:0]       hit_in [4][3];
  logic        [23:0]       col_in [3];
  logic        [3:0]        vld_in;
  logic                     halt_up;
  logic signed [23:0]       hit_out [3];
  logic        [23:0]       col_out [3];
  logic                     vld_out;
  logic                     halt_dn;
  logic        [3:0]        occ;
`ifdef HIT_SERIALIZER_STATS_EN
  logic [31:0] st_in, st_out, st_stall;
`endif

  hit_serializer dut (
    .clk            (clk),
    .rst            (rst),
    .hit_R18S       (hit_in),
    .color_R18U     (col_in),
    .hit_valid_R18H (vld_in),
    .halt_RnnnnL    (halt_up),
    .hit_R19S       (hit_out),
    .color_R19U     (col_out),
    .hit_valid_R19H (vld_out),
    .halt_R19L      (halt_dn),
    .occupancy      (occ)
`ifdef HIT_SERIALIZER_STATS_EN
    ,
    .hits_in        (st_in),
    .hits_out       (st_out),
    .stall_cycles   (st_stall)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Current drive values, mirrored for the queue model.
  bit [3:0] cur_v;
  int       cur_xb, cur_xs, cur_col;
  bit       cur_hl;

  // Lane i gets x = xb + i*xs, y = x+1, z = x+2; colour channel c = col + c.
  task automatic drive(input bit r, input bit [3:0] v, input int xb, input int xs,
                       input int col, input bit hl);
    rst    = r;
    vld_in = v;
    for (int i = 0; i < 4; i++)
      for (int a = 0; a < 3; a++) hit_in[i][a] = 24'(xb + i*xs + a);
    for (int c = 0; c < 3; c++) col_in[c] = 24'(col + c);
    halt_dn = hl;
    cur_v = v; cur_xb = xb; cur_xs = xs; cur_col = col; cur_hl = hl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    bit       r;
    bit [3:0] v;
    int       xb;
    int       xs;
    int       col;
    bit       hl;
    bit       ev;
    bit       eh;
    int       eo;
    int       ex;
    int       ec;
  } vec_t;

  function automatic vec_t mk(bit r, bit [3:0] v, int xb, int xs, int col, bit hl,
                              bit ev, bit eh, int eo, int ex, int ec);
    vec_t t;
    t.r = r; t.v = v; t.xb = xb; t.xs = xs; t.col = col; t.hl = hl;
    t.ev = ev; t.eh = eh; t.eo = eo; t.ex = ex; t.ec = ec;
    return t;
  endfunction

  vec_t tbl [16];

  // Reference FIFO of {x, colour} and stats tallies.
  int qx[$];
  int qc[$];
  int in_tally, out_tally, stall_tally;

  task automatic model_cycle(output bit acc);
    int sz;
    sz = qx.size();
    chk("m_halt",  halt_up, (sz <= 4) ? 1 : 0);
    chk("m_valid", vld_out, (sz != 0) ? 1 : 0);
    chk("m_occ",   occ, sz);
    if (sz != 0) begin
      chk("m_head_x",   hit_out[0], qx[0]);
      chk("m_head_z",   hit_out[2], qx[0] + 2);
      chk("m_head_col", col_out[1], qc[0] + 1);
    end
    acc = (sz <= 4);
    if (sz != 0 && cur_hl) begin
      void'(qx.pop_front());
      void'(qc.pop_front());
      out_tally++;
    end
    if (acc) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_v[i]) begin
          qx.push_back(cur_xb + i*cur_xs);
          qc.push_back(cur_col);
          in_tally++;
        end
      end
    end else if (cur_v != 4'b0) begin
      stall_tally++;
    end
    step();
  endtask

  task automatic wait_acc(input string nm);
    bit a;
    int n;
    n = 0;
    do begin
      model_cycle(a);
      n++;
    end while (!a && n < 40);
    chk({nm, "_accepted"}, a, 1);
  endtask

  task automatic drain(input string nm);
    bit a;
    int n;
    n = 0;
    drive(1'b1, 4'b0000, 0, 0, 0, 1'b1);
    while (qx.size() != 0 && n < 40) begin
      model_cycle(a);
      n++;
    end
    chk({nm, "_drained"}, qx.size(), 0);
    model_cycle(a);
  endtask

  initial begin
    bit a;
    in_tally = 0; out_tally = 0; stall_tally = 0;
    drive(1'b0, 4'b0000, 0, 0, 0, 1'b1);

    //            r  v     xb   xs   col hl   ev eh eo ex   ec
    tbl[0]  = mk(0, 4'h0,   0,   0,  0, 1,   0, 1, 0,   0,  0);
    tbl[1]  = mk(0, 4'hF, 500,   1,  9, 1,   0, 1, 0,   0,  0);
    tbl[2]  = mk(1, 4'hA,   0, 100,  7, 1,   1, 1, 2, 100,  7);
    tbl[3]  = mk(1, 4'h0,   0,   0,  0, 1,   1, 1, 1, 300,  7);
    tbl[4]  = mk(1, 4'h0,   0,   0,  0, 1,   0, 1, 0,   0,  0);
    tbl[5]  = mk(1, 4'hF,  10,   1, 20, 0,   1, 1, 4,  10, 20);
    tbl[6]  = mk(1, 4'hF,  14,   1, 21, 1,   1, 0, 7,  11, 20);
    tbl[7]  = mk(1, 4'h0,   0,   0,  0, 1,   1, 0, 6,  12, 20);
    tbl[8]  = mk(1, 4'h0,   0,   0,  0, 1,   1, 0, 5,  13, 20);
    tbl[9]  = mk(1, 4'h0,   0,   0,  0, 1,   1, 1, 4,  14, 21);
    tbl[10] = mk(1, 4'h0,   0,   0,  0, 0,   1, 1, 4,  14, 21);
    tbl[11] = mk(1, 4'h4,   0,  25, 30, 1,   1, 1, 4,  15, 21);
    tbl[12] = mk(1, 4'h0,   0,   0,  0, 1,   1, 1, 3,  16, 21);
    tbl[13] = mk(1, 4'h0,   0,   0,  0, 1,   1, 1, 2,  17, 21);
    tbl[14] = mk(1, 4'h0,   0,   0,  0, 1,   1, 1, 1,  50, 30);
    tbl[15] = mk(1, 4'h0,   0,   0,  0, 1,   0, 1, 0,   0,  0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].xb, tbl[i].xs, tbl[i].col, tbl[i].hl);
      step();
      chk($sformatf("v%0d_valid", i), vld_out, tbl[i].ev);
      chk($sformatf("v%0d_halt", i),  halt_up, tbl[i].eh);
      chk($sformatf("v%0d_occ", i),   occ,     tbl[i].eo);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_x", i),    hit_out[0], tbl[i].ex);
        chk($sformatf("v%0d_z", i),    hit_out[2], tbl[i].ex + 2);
        chk($sformatf("v%0d_col0", i), col_out[0], tbl[i].ec);
        chk($sformatf("v%0d_col2", i), col_out[2], tbl[i].ec + 2);
      end
      if (i == 0) chk("rst_head_x_cleared", hit_out[0], 0);
    end

    // Fill with the z-buffer stalled, then release and drain.
    drive(1'b1, 4'hF, 1000, 1, 100, 1'b0); wait_acc("fill_g0");
    drive(1'b1, 4'hF, 1004, 1, 101, 1'b0); wait_acc("fill_g1");
    drive(1'b1, 4'hF, 1008, 1, 102, 1'b0);
    for (int k = 0; k < 3; k++) begin
      model_cycle(a);
      chk("fill_g2_held", a, 0);
    end
    drive(1'b1, 4'hF, 1008, 1, 102, 1'b1); wait_acc("fill_g2");
    drive(1'b1, 4'hF, 1012, 1, 103, 1'b1); wait_acc("fill_g3");
    drain("fill");

    // Single-lane groups with continuous pop, wrapping both pointers.
    for (int g = 0; g < 20; g++) begin
      drive(1'b1, 4'b0001, 2000 + g, 0, 50, 1'b1);
      wait_acc($sformatf("wrap_g%0d", g));
      chk("wrap_occ_le1", (occ <= 1) ? 1 : 0, 1);
    end
    drain("wrap");

    // Reset with five entries in flight.
    drive(1'b1, 4'hF, 3000, 1, 60, 1'b0); wait_acc("mid_g0");
    drive(1'b1, 4'h1, 3004, 0, 61, 1'b0); wait_acc("mid_g1");
    chk("pre_rst_occ", occ, 5);
    drive(1'b0, 4'hF, 3100, 1, 62, 1'b0);
    step();
    chk("mid_rst_occ",   occ, 0);
    chk("mid_rst_valid", vld_out, 0);
    chk("mid_rst_halt",  halt_up, 1);
`ifdef HIT_SERIALIZER_STATS_EN
    chk("mid_rst_hits_in",  st_in, 0);
    chk("mid_rst_hits_out", st_out, 0);
    chk("mid_rst_stall",    st_stall, 0);
`endif
    qx.delete(); qc.delete();
    in_tally = 0; out_tally = 0; stall_tally = 0;
    drive(1'b1, 4'h0, 0, 0, 0, 1'b1);
    for (int k = 0; k < 3; k++) model_cycle(a);

    // Post-reset traffic, including a refused group to exercise stall counting.
    drive(1'b1, 4'hF, 4000, 1, 70, 1'b0); wait_acc("post_g0");
    drive(1'b1, 4'hF, 4004, 1, 71, 1'b0); wait_acc("post_g1");
    drive(1'b1, 4'hA, 4100, 1, 72, 1'b0);
    model_cycle(a);
    model_cycle(a);
    drive(1'b1, 4'hA, 4100, 1, 72, 1'b1); wait_acc("post_g2");
    drain("post");
`ifdef HIT_SERIALIZER_STATS_EN
    chk("stats_hits_in",  st_in, in_tally);
    chk("stats_hits_out", st_out, out_tally);
    chk("stats_stall",    st_stall, stall_tally);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hit_serializer.md
Name: hit_serializer

Overview:
- Sits directly downstream of the multi-sample test stage (R18) and upstream of the z-buffer write port.
- Takes up to MULTI_TEST hit lanes per cycle, each lane with its own hit_valid bit, plus one colour shared by the whole group.
- Compacts the valid lanes in lane order into a FIFO and emits one hit per cycle to the z-buffer over a valid/halt handshake.
- Back-pressures the sample-test pipeline when the FIFO cannot accept a full group.

Parameters:
- SIGFIG, 24, bits in each position/colour word.
- RADIX, 10, fraction bits (pass-through only; no arithmetic on it).
- AXIS, 3, axes per hit (x, y, z).
- COLORS, 3, colour channels.
- MULTI_TEST, 4, hit lanes per input group.
- DEPTH, 8, FIFO entries (one hit each); must be a power of 2 and >= MULTI_TEST.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- hit_R18S  input  signed [SIGFIG-1:0] x [MULTI_TEST][AXIS]  hit positions per lane.
- color_R18U  input  [SIGFIG-1:0] x [COLORS]  colour shared by the group.
- hit_valid_R18H  input  1 x [MULTI_TEST]  lane valid.
- halt_RnnnnL  output  1  upstream halt, active low; 0 = upstream must hold its R18 inputs.
- hit_R19S  output  signed [SIGFIG-1:0] x [AXIS]  head hit position.
- color_R19U  output  [SIGFIG-1:0] x [COLORS]  head hit colour.
- hit_valid_R19H  output  1  head entry valid.
- halt_R19L  input  1  downstream halt, active low; 0 = z-buffer not accepting.
- occupancy  output  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- **Storage:** DEPTH entries of {position, colour}, with a wr_ptr and rd_ptr of $clog2(DEPTH) bits each (wrap naturally) and a count register.
- **Halt:** halt_RnnnnL = (count <= DEPTH-MULTI_TEST), combinational from the count register only. It has no combinational path from any input.
- **Accept:** when halt_RnnnnL==1, every lane with hit_valid_R18H[i]==1 is written that cycle.
  - Writes go to slots wr_ptr, wr_ptr+1, … in ascending lane order.
  - Each written entry gets color_R18U.
  - npush = popcount(hit_valid_R18H), range 0..MULTI_TEST.
  - When halt_RnnnnL==0, inputs are ignored (npush=0).
- **Output:** first-word-fall-through.
  - hit_valid_R19H = (count != 0).
  - hit_R19S and color_R19U = entry[rd_ptr].
  - When count==0, the data outputs are don't-care but must not be X after reset: storage is cleared on reset.
- **Pop:** pop = hit_valid_R19H & halt_R19L. On pop, rd_ptr increments by 1.
- **Update:**
  - count_next = count + npush - pop.
  - wr_ptr_next = wr_ptr + npush.
  - Simultaneous push and pop is legal in any state, including count==DEPTH-MULTI_TEST with a full group.
- **Latency:** a hit accepted at cycle N is visible on hit_R19S at N+1 at the earliest, if the FIFO was empty.
- **Ordering:** strict FIFO, with lane order preserved inside a group. No reordering and no drops.
- **Empty:** pop is suppressed. halt_R19L is don't-care when hit_valid_R19H==0.
- **Full bound:** count never exceeds DEPTH, guaranteed by the halt rule. An overflow is an assertion failure.
- **Reset:** while rst==0 at a posedge, the next state is:
  - count=0, wr_ptr=0, rd_ptr=0, all storage = 0.
  - hit_valid_R19H=0, halt_RnnnnL=1, occupancy=0.
  - Any in-flight entries are discarded.
  - Inputs presented during a reset cycle are not captured.
- **Assertions (sim only):**
  - count <= DEPTH.
  - hit_R18S is stable while halt_RnnnnL==0 and any lane is valid.

Optional Feature:
- HIT_SERIALIZER_STATS_EN
- **Defined:** adds three 32-bit outputs.
  - hits_in: total lanes accepted.
  - hits_out: total pops.
  - stall_cycles: cycles with halt_RnnnnL==0 and at least one hit_valid_R18H set.
  - All three saturate at 32'hFFFF_FFFF and reset to 0.
- **Undefined:** these ports and counters do not exist. Core behaviour is identical in both cases.

Test Plan:
- Reset then an empty pipe, rst=0 for 2 cycles: hit_valid_R19H=0, halt_RnnnnL=1, occupancy=0 on the first posedge with rst=0.
- Single group hit_valid=4'b1010, lane1 x=100, lane3 x=300, halt_R19L=1: cycle+1 outputs x=100, cycle+2 outputs x=300, both with the group colour, then valid=0.
- Fill: halt_R19L=0, four groups of 4'b1111. halt_RnnnnL drops to 0 after group 2 (count=8). Groups 3-4 are held until halt_R19L=1; 16 hits then drain in order over 16 cycles.
- Boundary: count=4, push 4 and pop 1 in the same cycle -> count=7, halt_RnnnnL=0 next cycle; one more pop -> count=6, halt still 0; at count=4 -> halt_RnnnnL=1.
- Pointer wrap: 20 groups of 4'b0001 with continuous pop -> 20 hits out in order, occupancy never exceeds 1, ptr wraps at 8.
- Reset mid-operation with count=5: rst=0 one cycle -> count=0, hit_valid_R19H=0. No stale hit appears after release. Under HIT_SERIALIZER_STATS_EN all counters read 0.
